mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 30 +++
 rtl/mem_lane_ext.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access controller: access sizes,
// fault codes, FSM state constants and the alignment rule.
package mem_access_ctrl_pkg;

  localparam logic [1:0] DT_BYTE  = 2'b00;
  localparam logic [1:0] DT_HALF  = 2'b01;
  localparam logic [1:0] DT_WORD  = 2'b10;
  localparam logic [1:0] DT_DWORD = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACC1 = 3'd1;
  localparam logic [2:0] ST_ACC2 = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  // Natural alignment: the address must be a multiple of the access size.
  function automatic logic is_aligned(input logic [1:0] dtype, input logic [2:0] addr_lo);
    case (dtype)
      DT_BYTE: is_aligned = 1'b1;
      DT_HALF: is_aligned = (addr_lo[0] == 1'b0);
      DT_WORD: is_aligned = (addr_lo[1:0] == 2'b00);
      default: is_aligned = (addr_lo == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// Byte-lane steering between the 32-bit memory bus and sub-word accesses:
// byte enables, store replication and load extraction/extension.
module mem_lane_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_dtype,
  input  logic        i_sext,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  // Word and doubleword pass straight through; sub-word sizes are steered.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_dtype)
      DT_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_sext & w_byte[7]}}, w_byte};
      end
      DT_HALF: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_sext & w_half[15]}}, w_half};
      end
      default: begin
        o_be    = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store access controller: accepts one sized access, checks alignment,
// runs one or two word transfers on the memory port with an ack timeout.
//
// state | meaning
// IDLE  | waiting for a request, busy=0
// ACC1  | first (or only) word transfer; mem_req=0 here is the post-ack gap
// ACC2  | second word of a doubleword; mem_req=0 here is the post-ack gap
// DONE  | one-cycle completion pulse
// ERR   | one-cycle fault pulse (misaligned or timeout)
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_rw,
  input  logic [1:0]  i_dtype,
  input  logic        i_sext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata_lo,
  input  logic [31:0] i_wdata_hi,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_fault,
  output logic [31:0] o_rdata_lo,
  output logic [31:0] o_rdata_hi,
  output logic        o_mem_req,
  output logic        o_mem_rw,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    r_state;
  logic          r_rw;
  logic [1:0]    r_dtype;
  logic          r_sext;
  logic [1:0]    r_addr_lo;
  logic [31:0]   r_wdata_lo;
  logic [31:0]   r_wdata_hi;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_fault;
  logic [31:0]   r_rdata_lo;
  logic [31:0]   r_rdata_hi;

  logic          w_aligned;
  logic [31:0]   w_wdata_sel;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load;
  logic          w_tmo;

  assign w_aligned   = is_aligned(i_dtype, i_addr[2:0]);
  assign w_wdata_sel = (r_state == ST_ACC2) ? r_wdata_hi : r_wdata_lo;
  // Last waiting cycle before the budget is exhausted.
  assign w_tmo       = r_mem_req & ~i_mem_ack & (r_cnt == CW'(TIMEOUT - 1));

  mem_lane_ext u_lane (
    .i_dtype   (r_dtype),
    .i_sext    (r_sext),
    .i_addr_lo (r_addr_lo),
    .i_wdata   (w_wdata_sel),
    .i_rdata   (i_mem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_load)
  );

  // Access sequencing, request latching, timeout counting and load capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_rw       <= 1'b0;
      r_dtype    <= DT_BYTE;
      r_sext     <= 1'b0;
      r_addr_lo  <= 2'b00;
      r_wdata_lo <= '0;
      r_wdata_hi <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_fault    <= FAULT_NONE;
      r_rdata_lo <= '0;
      r_rdata_hi <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_rw       <= i_rw;
            r_dtype    <= i_dtype;
            r_sext     <= i_sext;
            r_addr_lo  <= i_addr[1:0];
            r_wdata_lo <= i_wdata_lo;
            r_wdata_hi <= i_wdata_hi;
            if (w_aligned) begin
              r_state    <= ST_ACC1;
              r_mem_req  <= 1'b1;
              r_cnt      <= '0;
              r_mem_addr <= {i_addr[31:2], 2'b00};
            end else begin
              r_state <= ST_ERR;
              r_fault <= FAULT_MISALIGN;
            end
          end
        end
        ST_ACC1, ST_ACC2: begin
          if (r_mem_req) begin
            if (i_mem_ack) begin
              r_mem_req <= 1'b0;
              if (r_rw) begin
                if (r_state == ST_ACC1) r_rdata_lo <= w_load;
                else                    r_rdata_hi <= w_load;
              end
            end else if (w_tmo) begin
              r_mem_req <= 1'b0;
              r_state   <= ST_ERR;
              r_fault   <= FAULT_TIMEOUT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_state == ST_ACC1 && r_dtype == DT_DWORD) begin
            r_state    <= ST_ACC2;
            r_mem_req  <= 1'b1;
            r_cnt      <= '0;
            r_mem_addr <= r_mem_addr + 32'd4;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
          r_fault <= FAULT_NONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_fault     = (r_state == ST_ERR) ? r_fault : FAULT_NONE;
  assign o_rdata_lo  = r_rdata_lo;
  assign o_rdata_hi  = r_rdata_hi;
  assign o_mem_req   = r_mem_req;
  assign o_mem_rw    = r_rw;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_req ? w_be : 4'b0000;
  assign o_mem_wdata = w_wdata;

endmodule
